// File: rtl/fma16_sum_seq.sv
// Multi-cycle fp16 +/-(x*y) +/- z front end producing the unrounded normalized sum for the rounder.
// Result valid 5 cycles after the accept cycle; held in DONE until outReady, inReady only in IDLE.
module fma16_sum_seq #(
    parameter int          SUMW = 34,
    parameter logic [15:0] QNAN = 16'h7e00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [15:0]     x,
    input  logic [15:0]     y,
    input  logic [15:0]     z,
    input  logic            mul,
    input  logic            add,
    input  logic            negp,
    input  logic            negz,
    output logic            outValid,
    input  logic            outReady,
    output logic [15:0]     sum,
    output logic [SUMW-1:0] fullSum,
    output logic            overFlowFlag,
    output logic            anyNaN
);

    localparam int AW  = SUMW + 2;
    // Both addends share a binary point at bit SUMW-2; the two top bits absorb the carry.
    localparam int PSH = SUMW - 22;
    localparam int ZSH = SUMW - 12;
    localparam logic signed [7:0] PT  = 8'(SUMW - 2);
    localparam logic [5:0]        TOP = 6'(SUMW - 1);

    typedef enum logic [2:0] {IDLE, MUL, ALIGN, ADD, NORM, DONE} state_t;
    state_t state, state_nxt;

    function automatic logic [AW-1:0] shr_st(input logic [AW-1:0] v, input logic [7:0] sh);
        logic [AW-1:0] mask;
        mask = ~({AW{1'b1}} << sh);
        return (v >> sh) | {{(AW-1){1'b0}}, |(v & mask)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inValid) state_nxt = MUL;
            MUL:     state_nxt = ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (outReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    logic [15:0] xr, yr, zr;
    logic        negp_r, negz_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            negp_r <= 1'b0;
            negz_r <= 1'b0;
        end else if (state == IDLE && inValid) begin
            xr     <= x;
            yr     <= mul ? y : 16'h3c00;
            zr     <= add ? z : 16'h0000;
            negp_r <= negp;
            negz_r <= negz;
        end
    end

    // Unpack and classify
    logic [10:0]        mx, my, mz_c;
    logic signed [7:0]  ex, ey, ez_c, ep_c;
    logic [21:0]        prod_c;
    logic               x_nan, y_nan, z_nan, x_inf, y_inf, z_inf, x_zero, y_zero, z_zero;
    logic               sp_c, sz_c, p_inf, invalid;

    always_comb begin
        mx     = {|xr[14:10], xr[9:0]};
        my     = {|yr[14:10], yr[9:0]};
        mz_c   = {|zr[14:10], zr[9:0]};
        ex     = (xr[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, xr[14:10]});
        ey     = (yr[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, yr[14:10]});
        ez_c   = (zr[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, zr[14:10]});
        ep_c   = ex + ey - 8'sd15;
        prod_c = 22'(mx) * 22'(my);
        x_nan  = (&xr[14:10]) & (|xr[9:0]);
        y_nan  = (&yr[14:10]) & (|yr[9:0]);
        z_nan  = (&zr[14:10]) & (|zr[9:0]);
        x_inf  = (&xr[14:10]) & ~(|xr[9:0]);
        y_inf  = (&yr[14:10]) & ~(|yr[9:0]);
        z_inf  = (&zr[14:10]) & ~(|zr[9:0]);
        x_zero = ~(|xr[14:0]);
        y_zero = ~(|yr[14:0]);
        z_zero = ~(|zr[14:0]);
        sp_c   = xr[15] ^ yr[15] ^ negp_r;
        sz_c   = zr[15] ^ negz_r;
        p_inf  = x_inf | y_inf;
        invalid = x_nan | y_nan | z_nan | (x_inf & y_zero) | (y_inf & x_zero)
                | (p_inf & z_inf & (sp_c != sz_c));
    end

    logic [21:0]       prod_q;
    logic [10:0]       mz_q;
    logic signed [7:0] ep_q, ez_q;
    logic              sp_q, sz_q, pz_q, zz_q, nan_q, inf_q, infs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            mz_q   <= '0;
            ep_q   <= '0;
            ez_q   <= '0;
            sp_q   <= 1'b0;
            sz_q   <= 1'b0;
            pz_q   <= 1'b0;
            zz_q   <= 1'b0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            infs_q <= 1'b0;
        end else if (state == MUL) begin
            prod_q <= prod_c;
            mz_q   <= mz_c;
            ep_q   <= ep_c;
            ez_q   <= ez_c;
            sp_q   <= sp_c;
            sz_q   <= sz_c;
            pz_q   <= x_zero | y_zero;
            zz_q   <= z_zero;
            nan_q  <= invalid;
            inf_q  <= ~invalid & (p_inf | z_inf);
            infs_q <= p_inf ? sp_c : sz_c;
        end
    end

    // Alignment: the smaller-exponent addend is shifted right with sticky collection
    logic [AW-1:0]     av0, bv0, av_c, bv_c;
    logic signed [7:0] d_c, e_c;
    logic [7:0]        nd_c;

    always_comb begin
        av0  = AW'(prod_q) << PSH;
        bv0  = AW'(mz_q) << ZSH;
        d_c  = ep_q - ez_q;
        nd_c = -d_c;
        av_c = av0;
        bv_c = bv0;
        e_c  = ep_q;
        if (pz_q) begin
            av_c = '0;
            e_c  = ez_q;
        end else if (zz_q) begin
            bv_c = '0;
        end else if (d_c >= 8'sd0) begin
            bv_c = shr_st(bv0, d_c);
        end else begin
            av_c = shr_st(av0, nd_c);
            e_c  = ez_q;
        end
    end

    logic [AW-1:0]     av_q, bv_q, r_q;
    logic signed [7:0] e_q;
    logic              rs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            av_q <= '0;
            bv_q <= '0;
            e_q  <= '0;
            r_q  <= '0;
            rs_q <= 1'b0;
        end else if (state == ALIGN) begin
            av_q <= av_c;
            bv_q <= bv_c;
            e_q  <= e_c;
        end else if (state == ADD) begin
            if (sp_q == sz_q) begin
                r_q  <= av_q + bv_q;
                rs_q <= sp_q;
            end else if (av_q >= bv_q) begin
                r_q  <= av_q - bv_q;
                rs_q <= sp_q;
            end else begin
                r_q  <= bv_q - av_q;
                rs_q <= sz_q;
            end
        end
    end

    // Normalize: leading one to bit SUMW-1, then denormalize if the exponent underflows
    logic [5:0]        lead;
    logic signed [7:0] eb_c;
    logic [7:0]        dsh;
    logic [AW-1:0]     nrm, sub;
    logic [15:0]       sum_c;
    logic [SUMW-1:0]   full_c;
    logic              ovf_c, nan_c;

    always_comb begin
        lead = '0;
        for (int i = 0; i < AW; i++) begin
            if (r_q[i]) lead = 6'(i);
        end
        eb_c = e_q + $signed({2'b00, lead}) - PT;
        if (lead > TOP) nrm = shr_st(r_q, {2'b00, lead - TOP});
        else            nrm = r_q << (TOP - lead);
        dsh    = 8'(8'sd1 - eb_c);
        sub    = shr_st(nrm, dsh);
        sum_c  = 16'h0000;
        full_c = '0;
        ovf_c  = 1'b0;
        nan_c  = 1'b0;
        if (nan_q) begin
            sum_c = QNAN;
            nan_c = 1'b1;
        end else if (inf_q) begin
            sum_c = {infs_q, 15'h7c00};
        end else if (r_q != '0) begin
            if (eb_c < 8'sd1) begin
                full_c = SUMW'(sub);
                sum_c  = {rs_q, 5'd0, sub[SUMW-2 -: 10]};
            end else begin
                full_c = SUMW'(nrm);
                if (eb_c >= 8'sd31) begin
                    ovf_c = 1'b1;
                    sum_c = {rs_q, 15'h7c00};
                end else begin
                    sum_c = {rs_q, eb_c[4:0], nrm[SUMW-2 -: 10]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum          <= '0;
            fullSum      <= '0;
            overFlowFlag <= 1'b0;
            anyNaN       <= 1'b0;
        end else if (state == NORM) begin
            sum          <= sum_c;
            fullSum      <= full_c;
            overFlowFlag <= ovf_c;
            anyNaN       <= nan_c;
        end
    end

endmodule

// File: tb/tb_fma16_sum_seq.sv
// Bench for fma16_sum_seq: vector table through a scoreboard queue, plus stall and mid-op reset sequences.
module tb_fma16_sum_seq;

    logic        clk = 1'b0;
    logic        reset, inValid, inReady, mul, add, negp, negz;
    logic        outValid, outReady, overFlowFlag, anyNaN;
    logic [15:0] x, y, z, sum;
    logic [33:0] fullSum;

    fma16_sum_seq dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp), .negz(negz),
        .outValid(outValid), .outReady(outReady), .sum(sum), .fullSum(fullSum),
        .overFlowFlag(overFlowFlag), .anyNaN(anyNaN)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x, y, z;
        logic        mul, add, negp, negz;
        logic [15:0] esum;
        logic [33:0] efull;
        logic        eovf, enan;
    } vec_t;

    typedef struct {
        logic [15:0] esum;
        logic [33:0] efull;
        logic        eovf, enan;
        int          acc;
    } exp_t;

    vec_t vecs[14];
    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Output monitor: latency on the first valid cycle, result check on each handshake
    always @(negedge clk) begin
        if (outValid && !prev_ov && q.size() > 0)
            chk("latency", 64'(cyc - q[0].acc), 64'd5);
        prev_ov = outValid;
        if (outValid && outReady) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(outValid), 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("sum", 64'(sum), 64'(mon_e.esum));
                chk("fullSum", 64'(fullSum), 64'(mon_e.efull));
                chk("overFlowFlag", 64'(overFlowFlag), 64'(mon_e.eovf));
                chk("anyNaN", 64'(anyNaN), 64'(mon_e.enan));
            end
        end
    end

    task automatic apply(input vec_t v);
        int   n;
        exp_t e;
        x = v.x; y = v.y; z = v.z;
        mul = v.mul; add = v.add; negp = v.negp; negz = v.negz;
        inValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(inReady), 64'd1);
        if (inReady) begin
            e.esum = v.esum; e.efull = v.efull; e.eovf = v.eovf; e.enan = v.enan;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        //          x        y        z        mul   add   negp  negz  sum      fullSum          ovf   nan
        vecs[0]  = '{16'h3c00, 16'h4000, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4200, 34'h3_0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{16'h3c01, 16'h3c01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h3c02, 34'h2_0100_2000, 1'b0, 1'b0};
        vecs[2]  = '{16'h7c00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7e00, 34'h0,           1'b0, 1'b1};
        vecs[3]  = '{16'h7bff, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7c00, 34'h3_ff80_0000, 1'b1, 1'b0};
        vecs[4]  = '{16'h3c00, 16'h3c00, 16'hbc00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 34'h0,           1'b0, 1'b0};
        vecs[5]  = '{16'h4000, 16'h1234, 16'h3c00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4200, 34'h3_0000_0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h3c00, 16'h4000, 16'h7c00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 34'h2_0000_0000, 1'b0, 1'b0};
        vecs[7]  = '{16'h3c00, 16'h4000, 16'h3c00, 1'b1, 1'b1, 1'b1, 1'b0, 16'hbc00, 34'h2_0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{16'h7c00, 16'h4000, 16'h3c00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7c00, 34'h0,           1'b0, 1'b0};
        vecs[9]  = '{16'h7c00, 16'h3c00, 16'h7c00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7e00, 34'h0,           1'b0, 1'b1};
        vecs[10] = '{16'h3c00, 16'h3c00, 16'h7e01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7e00, 34'h0,           1'b0, 1'b1};
        vecs[11] = '{16'h0000, 16'h4000, 16'h4200, 1'b1, 1'b1, 1'b0, 1'b1, 16'hc200, 34'h3_0000_0000, 1'b0, 1'b0};
        vecs[12] = '{16'h0400, 16'h3800, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 34'h1_0000_0000, 1'b0, 1'b0};
        vecs[13] = '{16'h5a00, 16'h5a00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7880, 34'h2_4000_0001, 1'b0, 1'b0};

        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        x = '0; y = '0; z = '0; mul = 1'b1; add = 1'b1; negp = 1'b0; negz = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outValid", 64'(outValid), 64'd0);
        chk("reset_inReady", 64'(inReady), 64'd1);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_fullSum", 64'(fullSum), 64'd0);
        chk("reset_overFlowFlag", 64'(overFlowFlag), 64'd0);
        chk("reset_anyNaN", 64'(anyNaN), 64'd0);
        @(posedge clk);
        #2;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            drain();
        end

        // Back-pressure: result must hold while outReady is low and a new op is offered
        outReady = 1'b0;
        apply(vecs[1]);
        for (int n = 0; n < 20 && !outValid; n++) @(negedge clk);
        chk("stall_reached", 64'(outValid), 64'd1);
        @(posedge clk);
        #2;
        inValid = 1'b1; x = 16'h4000; y = 16'h4000; z = 16'h4000;
        repeat (3) begin
            @(negedge clk);
            chk("stall_outValid", 64'(outValid), 64'd1);
            chk("stall_inReady", 64'(inReady), 64'd0);
            chk("stall_sum", 64'(sum), 64'(vecs[1].esum));
            chk("stall_fullSum", 64'(fullSum), 64'(vecs[1].efull));
        end
        @(posedge clk);
        #2;
        inValid = 1'b0;
        outReady = 1'b1;
        drain();

        // Reset while the op sits in ALIGN: no output, then a clean op afterwards
        apply(vecs[3]);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_outValid", 64'(outValid), 64'd0);
        chk("midrst_inReady", 64'(inReady), 64'd1);
        chk("midrst_sum", 64'(sum), 64'd0);
        q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        apply(vecs[13]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
